arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles a channel waits in REQ for a grant before abandoning; legal range 2..255.
REQ-002 Parameter LEN_W, default 4: width of the burst-length field.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 job_valid  input  2  per-channel job offer from the upstream client; bit i is channel i.
REQ-006 job_len  input  2*LEN_W  per-channel burst length in beats; slice i is [i*LEN_W +: LEN_W]; 0 means 1 beat.
REQ-007 job_ready  output  2  per-channel job acceptance.
REQ-008 grant  input  2  grant vector from the arbiter; bit i grants channel i.
REQ-009 request  output  2  request vector to the arbiter; bit i belongs to channel i.
REQ-010 beat_valid  output  2  per-channel, one transferred beat this cycle.
REQ-011 done  output  2  per-channel, one-cycle pulse when a burst completes.
REQ-012 timeout  output  2  per-channel, one-cycle pulse when a request is abandoned.

Function
REQ-013 The two channels are independent and identical; no output of channel i depends on any input bit of channel j.
REQ-014 Each channel SHALL implement FSM states IDLE, REQ, XFER and RELEASE.
REQ-015 IDLE: job_ready[i]=1, request[i]=0. On job_valid[i]=1, latch remaining=max(job_len_i,1), clear wait_cnt, and go to REQ next cycle.
REQ-016 REQ: request[i]=1, job_ready[i]=0. If grant[i]=1 is sampled, go to XFER. Otherwise increment wait_cnt.
REQ-017 REQ timeout: if wait_cnt==TIMEOUT-1 and grant[i]=0, pulse timeout[i] for one cycle, return to IDLE, and drop request[i] in the same edge. request[i] is high for exactly TIMEOUT cycles.
REQ-018 XFER: request[i]=1. beat_valid[i]=grant[i], combinationally.
REQ-019 XFER decrement: remaining decrements on every cycle where grant[i]=1.
REQ-020 XFER stall: if grant[i] falls mid-burst, beats stall, request[i] stays high, and no timeout applies in XFER.
REQ-021 XFER completion: a beat with remaining==1 is the last beat. The next state is RELEASE.
REQ-022 RELEASE: request[i]=0, job_ready[i]=0, done[i]=1 for exactly one cycle, then IDLE. This guarantees at least one idle request cycle between bursts.
REQ-023 grant[i]=1 while the channel is in IDLE or RELEASE SHALL be ignored: no beat and no state change.
REQ-024 grant=2'b11, which is illegal from the arbiter, SHALL be handled per channel with no cross-channel interaction.
REQ-025 Latency from job acceptance to request high is 1 cycle. Latency from the first sampled grant to the first beat is 1 cycle.
REQ-026 A burst of N beats under continuous grant occupies XFER for exactly N cycles.
REQ-027 wait_cnt and remaining SHALL not wrap: wait_cnt saturates at TIMEOUT-1, and remaining is never decremented below 1 in XFER.

Reset
REQ-028 rst=1 asynchronously forces both FSMs to IDLE and clears remaining and wait_cnt.
REQ-029 During reset: request=2'b00, beat_valid=2'b00, done=2'b00, timeout=2'b00, job_ready=2'b11.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no done or timeout pulse. The job is discarded.
REQ-031 After rst deasserts, the first job acceptance SHALL occur on the first rising edge with job_valid high.

Structure
REQ-032 A shared package arb_pkg SHALL hold the FSM state enum (IDLE, REQ, XFER, RELEASE), the channel count constant NUM_CH=2, and the default TIMEOUT and LEN_W values.
REQ-033 The per-channel FSM and counters SHALL be one sub-module, arb_req_chan, instantiated twice by arb_requester through a generate loop.
REQ-034 arb_requester SHALL contain only wiring and slicing, with no logic of its own.

Verification
REQ-035 Basic burst, channel 0:
- Stimulus: job_valid=01, job_len=3; grant[0] held high from the cycle after request[0] rises.
- Response: request[0] high for 4 cycles, beat_valid[0] high for 3 consecutive cycles, done[0] pulses once, request[0] low for at least 1 cycle.
REQ-036 Timeout, TIMEOUT=16:
- Stimulus: job on channel 1; grant held 00.
- Response: request[1] high for exactly 16 cycles, timeout[1] pulses once, channel returns to IDLE (job_ready[1]=1), beat_valid[1] never asserted.
REQ-037 Grant stall:
- Stimulus: job_len=4; grant[0] pattern 1,1,0,0,1,1.
- Response: beat_valid[0] pattern 1,1,0,0,1,1; request[0] stays high throughout; done[0] after the 4th beat.
REQ-038 Concurrent channels:
- Stimulus: simultaneous jobs with len 2 (channel 0) and len 5 (channel 1); grant=11 continuously.
- Response: done[0] 3 cycles before done[1]; no cross-channel effects.
REQ-039 Reset mid-burst:
- Stimulus: rst pulsed after the 2nd of 8 beats.
- Response: request=00 immediately (asynchronously), no done or timeout pulse, job_ready=11; a new len=1 job after reset completes normally.
REQ-040 Zero length and spurious grant:
- Stimulus: job_len=0; grant[0]=1 asserted while the channel is in IDLE.
- Response: the spurious grant causes no beat. The zero-length job then produces exactly 1 beat and 1 done pulse.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-channel arbiter requester.
package arb_pkg;
    localparam int NUM_CH      = 2;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_e;
endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: job accepted in IDLE, request 1 cycle later, beats follow grant 1 cycle after it is sampled.
// Backpressure: grant low stalls XFER indefinitely; grant low in REQ for TIMEOUT cycles abandons the job.
module arb_req_chan import arb_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_job_valid,
    input  logic [LEN_W-1:0] i_job_len,
    output logic             o_job_ready,
    input  logic             i_grant,
    output logic             o_request,
    output logic             o_beat_valid,
    output logic             o_done,
    output logic             o_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [LEN_W-1:0] r_remaining;
    logic             r_timeout;
    logic             w_wait_last;
    logic             w_last_beat;

    assign w_wait_last = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last_beat = (r_remaining == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_job_valid) w_state_nxt = REQ;
            REQ: begin
                if (i_grant)          w_state_nxt = XFER;
                else if (w_wait_last) w_state_nxt = IDLE;
            end
            XFER:    if (i_grant && w_last_beat) w_state_nxt = RELEASE;
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // wait_cnt never passes TIMEOUT-1 because REQ is left on that cycle either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_remaining <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= (r_state == REQ) && !i_grant && w_wait_last;
            if (r_state == IDLE && i_job_valid) begin
                r_wait_cnt  <= '0;
                r_remaining <= (i_job_len == '0) ? LEN_W'(1) : i_job_len;
            end else if (r_state == REQ && !i_grant && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else if (r_state == XFER && i_grant && !w_last_beat) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    always_comb begin
        o_job_ready  = (r_state == IDLE);
        o_request    = (r_state == REQ) || (r_state == XFER);
        o_beat_valid = (r_state == XFER) && i_grant;
        o_done       = (r_state == RELEASE);
        o_timeout    = r_timeout;
    end
endmodule

// File: rtl/arb_requester.sv
// Two independent requester channels sliced out of shared vectors; no logic beyond wiring.
// Latency and backpressure are those of arb_req_chan, per channel.
module arb_requester import arb_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       job_valid,
    input  logic [NUM_CH*LEN_W-1:0] job_len,
    output logic [NUM_CH-1:0]       job_ready,
    input  logic [NUM_CH-1:0]       grant,
    output logic [NUM_CH-1:0]       request,
    output logic [NUM_CH-1:0]       beat_valid,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       timeout
);
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        arb_req_chan #(
            .TIMEOUT (TIMEOUT),
            .LEN_W   (LEN_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_job_valid  (job_valid[gi]),
            .i_job_len    (job_len[gi*LEN_W +: LEN_W]),
            .o_job_ready  (job_ready[gi]),
            .i_grant      (grant[gi]),
            .o_request    (request[gi]),
            .o_beat_valid (beat_valid[gi]),
            .o_done       (done[gi]),
            .o_timeout    (timeout[gi])
        );
    end
endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios plus random traffic against a job-level reference model.
module tb_arb_requester;
    localparam int T  = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    job_valid, job_ready, grant, request, beat_valid, done, timeout;
    logic [2*LW-1:0] job_len;

    arb_requester #(.TIMEOUT(T), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_len    (job_len),
        .job_ready  (job_ready),
        .grant      (grant),
        .request    (request),
        .beat_valid (beat_valid),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a job is either waiting for grant, transferring, or finishing.
    bit m_busy[2], m_granted[2], m_finish[2], m_to[2];
    int m_waited[2], m_left[2];

    int t_req[2], t_beat[2], t_done[2], t_to[2], done_cyc[2];
    logic [5:0] beat_trace;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = 0; m_granted[c] = 0; m_finish[c] = 0; m_to[c] = 0;
            m_waited[c] = 0; m_left[c] = 0;
        end
    endtask

    task automatic tally_clear();
        for (int c = 0; c < 2; c++) begin
            t_req[c] = 0; t_beat[c] = 0; t_done[c] = 0; t_to[c] = 0; done_cyc[c] = -1;
        end
    endtask

    task automatic step(input logic [1:0] jv, input logic [2*LW-1:0] jl, input logic [1:0] g);
        logic [1:0] e_rdy, e_req, e_beat, e_done, e_to;
        int len;
        #1;
        job_valid = jv; job_len = jl; grant = g;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            e_rdy[c]  = !m_busy[c] && !m_finish[c];
            e_req[c]  = m_busy[c];
            e_beat[c] = m_busy[c] && m_granted[c] && g[c];
            e_done[c] = m_finish[c];
            e_to[c]   = m_to[c];
        end
        check_eq("job_ready", {30'd0, job_ready}, {30'd0, e_rdy});
        check_eq("request", {30'd0, request}, {30'd0, e_req});
        check_eq("beat_valid", {30'd0, beat_valid}, {30'd0, e_beat});
        check_eq("done", {30'd0, done}, {30'd0, e_done});
        check_eq("timeout", {30'd0, timeout}, {30'd0, e_to});
        for (int c = 0; c < 2; c++) begin
            t_req[c]  += int'(request[c]);
            t_beat[c] += int'(beat_valid[c]);
            t_done[c] += int'(done[c]);
            t_to[c]   += int'(timeout[c]);
            if (done[c]) done_cyc[c] = cyc;
        end
        @(posedge clk);
        cyc++;
        for (int c = 0; c < 2; c++) begin
            bit to_now;
            to_now = 0;
            len = int'(jl[c*LW +: LW]);
            if (m_finish[c]) begin
                m_finish[c] = 0;
            end else if (!m_busy[c]) begin
                if (jv[c]) begin
                    m_busy[c] = 1; m_granted[c] = 0; m_waited[c] = 0;
                    m_left[c] = (len == 0) ? 1 : len;
                end
            end else if (!m_granted[c]) begin
                if (g[c]) m_granted[c] = 1;
                else if (m_waited[c] + 1 >= T) begin
                    m_busy[c] = 0; to_now = 1;
                end else m_waited[c]++;
            end else if (g[c]) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_busy[c] = 0; m_finish[c] = 1;
                end
            end
            m_to[c] = to_now;
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1; job_valid = '0; grant = '0; job_len = '0;
        #1;
        check_eq("rst_request", {30'd0, request}, 32'd0);
        check_eq("rst_beat", {30'd0, beat_valid}, 32'd0);
        check_eq("rst_done", {30'd0, done}, 32'd0);
        check_eq("rst_timeout", {30'd0, timeout}, 32'd0);
        check_eq("rst_ready", {30'd0, job_ready}, 32'd3);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        logic [1:0] g;
        rst = 1'b1; job_valid = '0; grant = '0; job_len = '0;
        model_clear();
        tally_clear();
        #12;
        do_reset();

        // Basic burst on channel 0, len 3
        tally_clear();
        step(2'b01, {4'd0, 4'd3}, 2'b00);
        for (int i = 0; i < 6; i++) step(2'b00, '0, 2'b01);
        check_eq("basic_req_cycles", t_req[0], 4);
        check_eq("basic_beats", t_beat[0], 3);
        check_eq("basic_done", t_done[0], 1);

        // Timeout on channel 1 with no grant
        tally_clear();
        step(2'b10, {4'd3, 4'd0}, 2'b00);
        for (int i = 0; i < 17; i++) step(2'b00, '0, 2'b00);
        check_eq("to_req_cycles", t_req[1], T);
        check_eq("to_pulses", t_to[1], 1);
        check_eq("to_beats", t_beat[1], 0);
        #1;
        check_eq("to_ready", {31'd0, job_ready[1]}, 32'd1);

        // Grant stall mid-burst
        tally_clear();
        step(2'b01, {4'd0, 4'd4}, 2'b00);
        step(2'b00, '0, 2'b01);
        for (int i = 0; i < 6; i++) begin
            g = (i == 2 || i == 3) ? 2'b00 : 2'b01;
            step(2'b00, '0, g);
            beat_trace[5-i] = beat_valid[0];
        end
        step(2'b00, '0, 2'b00);
        step(2'b00, '0, 2'b00);
        check_eq("stall_pattern", {26'd0, beat_trace}, 32'b110011);
        check_eq("stall_req_cycles", t_req[0], 7);
        check_eq("stall_done", t_done[0], 1);

        // Concurrent channels with grant=11
        tally_clear();
        step(2'b11, {4'd5, 4'd2}, 2'b11);
        for (int i = 0; i < 9; i++) step(2'b00, '0, 2'b11);
        check_eq("conc_done_gap", done_cyc[1] - done_cyc[0], 3);
        check_eq("conc_beats0", t_beat[0], 2);
        check_eq("conc_beats1", t_beat[1], 5);

        // Reset after the second of eight beats
        tally_clear();
        step(2'b01, {4'd0, 4'd8}, 2'b00);
        for (int i = 0; i < 3; i++) step(2'b00, '0, 2'b01);
        do_reset();
        check_eq("rst_mid_done", t_done[0] + t_to[0], 0);
        tally_clear();
        step(2'b01, {4'd0, 4'd1}, 2'b00);
        for (int i = 0; i < 4; i++) step(2'b00, '0, 2'b01);
        check_eq("post_rst_beats", t_beat[0], 1);
        check_eq("post_rst_done", t_done[0], 1);

        // Spurious grant in IDLE, then a zero-length job
        tally_clear();
        for (int i = 0; i < 3; i++) step(2'b00, '0, 2'b01);
        check_eq("spurious_beats", t_beat[0], 0);
        step(2'b01, {4'd0, 4'd0}, 2'b00);
        for (int i = 0; i < 4; i++) step(2'b00, '0, 2'b01);
        check_eq("zero_len_beats", t_beat[0], 1);
        check_eq("zero_len_done", t_done[0], 1);

        // Random traffic, grant density sweeping from none to always
        for (int i = 0; i < 800; i++) begin
            int dens;
            dens = (i / 100) % 5;
            g[0] = ($urandom_range(0, 3) < dens);
            g[1] = ($urandom_range(0, 3) < dens);
            step(2'($urandom), 8'($urandom), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
